neander_prog_loader: RTL and testbench
======================================

// Module: neander_prog_loader
// PURPOSE
//   Upstream loader for the Neander CPU: accepts a byte stream over a valid/ready link,
//   writes it into program/data memory, and holds the CPU in reset until loading completes.
//   Stream format: one length byte N, then N payload bytes written to START_ADDR..START_ADDR+N-1.
//   Drives the memory write port and the CPU reset while loading; idle otherwise.
// PARAMETERS
//   START_ADDR  8'h00  address of the first payload byte
//   MAX_LEN     128    largest accepted N; START_ADDR+MAX_LEN <= 256 (elaboration error otherwise)
// PORTS
//   clk         in   1  system clock, rising edge
//   rst         in   1  asynchronous, active-high reset
//   start       in   1  1-cycle pulse: begin a load session
//   in_valid    in   1  source has a byte on in_data
//   in_data     in   8  stream byte
//   in_ready    out  1  loader accepts a byte this cycle
//   mem_we      out  1  memory write strobe, 1 cycle per payload byte
//   mem_addr    out  8  memory write address
//   mem_wdata   out  8  memory write data
//   cpu_rst     out  1  hold CPU in reset (1 = held)
//   busy        out  1  session in progress
//   done        out  1  last session completed successfully
//   err         out  1  last session aborted
//   byte_count  out  8  payload bytes written in the current/last session
// BEHAVIOUR
//   Reset (async): state IDLE; cpu_rst=1; in_ready, mem_we, busy, done, err = 0;
//     mem_addr, mem_wdata, byte_count = 0. The CPU is never released before a successful load.
//   Handshake: a byte transfers on a clk edge with in_valid & in_ready.
//     in_ready is decoded from state only (1 in LEN, DATA, CSUM) and does not depend on in_valid.
//   FSM states: IDLE, LEN, DATA, CSUM (macro builds only), DONE, ERROR.
//   IDLE:  start -> LEN, busy=1, cpu_rst=1, done=0, err=0, byte_count=0.
//   LEN:   on transfer, N=in_data. N==0 or N>MAX_LEN -> ERROR. Otherwise latch N, cnt=0 -> DATA.
//   DATA:  on transfer, the cycle after the transfer: mem_we=1, mem_addr=START_ADDR+cnt,
//            mem_wdata=byte. Write latency is 1 cycle.
//          cnt and byte_count increment. When the transfer holds byte N -> DONE (or CSUM).
//          Back-to-back transfers write on consecutive cycles; in_valid gaps simply stall.
//   DONE:  cpu_rst=0, done=1, busy=0. start -> LEN and reasserts cpu_rst that same edge.
//   ERROR: err=1, busy=0, cpu_rst=1. start -> LEN and clears err.
//   start while busy (LEN/DATA/CSUM) is ignored. Outputs are held during stall cycles.
//   mem_addr/mem_wdata keep the last written values when mem_we=0.
//   Address arithmetic is 8-bit modulo 256 and cannot wrap, given the parameter constraint.
//   Reset mid-session: async return to IDLE. Partially written memory is not undone.
// CONFIGURATION
//   LOADER_CHECKSUM_EN defined:
//     - After byte N, the FSM enters CSUM and expects one more byte: the 8-bit sum mod 256
//       of the N payload bytes.
//     - Match -> DONE. Mismatch -> ERROR. The checksum byte is never written to memory.
//   LOADER_CHECKSUM_EN undefined:
//     - No CSUM state and no sum register.
//     - The FSM goes DATA -> DONE directly after byte N.
// STRUCTURE
//   Shared package neander_pkg:
//     - FSM state encoding localparams
//     - RAM base 8'h80
//     - MAX_LEN default
//   Sub-module neander_loader_csum (clear, add-enable, 8-bit running sum, compare):
//     instantiated only under LOADER_CHECKSUM_EN.
//   Address/count increment reuses the codebase 8-bit adder. State register uses the reset flop.
// TESTING
//   1. Reset, start, stream 03,11,22,33 with in_valid held high
//        -> writes 11@00, 22@01, 33@02 on 3 consecutive cycles; done=1; cpu_rst=0; byte_count=3.
//   2. Length 00, and separately length 8'h81 (MAX_LEN=128)
//        -> ERROR, err=1, cpu_rst=1, no mem_we pulses.
//   3. Stream 02,AA,BB with 2-cycle in_valid gaps
//        -> in_ready stays high; exactly 2 mem_we pulses (AA@00, BB@01).
//   4. Assert rst between payload bytes 1 and 2 of a 4-byte load
//        -> immediate IDLE, cpu_rst=1, busy=0.
//        A following clean start+load succeeds.
//   5. start pulse mid-DATA
//        -> ignored, session completes normally.
//        start in DONE -> cpu_rst re-rises and a new load begins.
//   6. LOADER_CHECKSUM_EN: 02,01,02,03 -> DONE. 02,01,02,04 -> ERROR, cpu_rst=1.
//        The checksum byte is never written.

Source files
------------

// File: rtl/neander_pkg.sv
// Shared definitions for the Neander loader: FSM encoding, memory map
// constants and the 8-bit modulo adder used for address/count arithmetic.
package neander_pkg;

    localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
    localparam logic [2:0] ST_LEN_ENC   = 3'd1;
    localparam logic [2:0] ST_DATA_ENC  = 3'd2;
    localparam logic [2:0] ST_CSUM_ENC  = 3'd3;
    localparam logic [2:0] ST_DONE_ENC  = 3'd4;
    localparam logic [2:0] ST_ERROR_ENC = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_LEN   = ST_LEN_ENC,
        ST_DATA  = ST_DATA_ENC,
        ST_CSUM  = ST_CSUM_ENC,
        ST_DONE  = ST_DONE_ENC,
        ST_ERROR = ST_ERROR_ENC
    } state_t;

    // Base of the data RAM region in the Neander memory map.
    localparam logic [7:0] RAM_BASE = 8'h80;

    localparam int MAX_LEN_DEFAULT = 128;

    // 8-bit adder, result wraps modulo 256.
    function automatic logic [7:0] add8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/neander_prog_loader_if.sv
// Byte stream input and memory write port of the program loader.
// master = stream source / memory side, slave = loader.
interface neander_prog_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/neander_loader_csum.sv
// Running 8-bit modulo-256 sum of payload bytes with an equality compare.
// Only present in builds with LOADER_CHECKSUM_EN defined.
`ifdef LOADER_CHECKSUM_EN
module neander_loader_csum
    import neander_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       add_en,
    input  logic [7:0] din,
    input  logic [7:0] cmp,
    output logic       match
);

    logic [7:0] sum_reg;

    // Accumulate payload bytes; clear wins at session start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_reg <= 8'h00;
        end else if (clear) begin
            sum_reg <= 8'h00;
        end else if (add_en) begin
            sum_reg <= add8(sum_reg, din);
        end
    end

    assign match = (sum_reg == cmp);

endmodule
`endif

// File: rtl/neander_prog_loader.sv
// Neander program loader: takes a length-prefixed byte stream, writes the
// payload into memory from START_ADDR and holds the CPU in reset until a
// load session finishes cleanly.
// Optional feature macro: LOADER_CHECKSUM_EN (adds a trailing sum byte check).
module neander_prog_loader
    import neander_pkg::*;
#(
    parameter logic [7:0] START_ADDR = 8'h00,
    parameter int         MAX_LEN    = MAX_LEN_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    neander_prog_loader_if.slave        lnk,
    output logic                        cpu_rst,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [7:0]                  byte_count
);

    // The payload must fit below the top of the 8-bit address space.
    if (int'(START_ADDR) + MAX_LEN > 256) begin : g_bad_params
        $error("neander_prog_loader: START_ADDR + MAX_LEN exceeds 256");
    end

    state_t     state_reg, state_next;
    logic [7:0] len_reg;
    logic [7:0] cnt_reg;
    logic       mem_we_reg;
    logic [7:0] mem_addr_reg;
    logic [7:0] mem_wdata_reg;
    logic       load_start;
    logic       xfer;
    logic       data_xfer;
    logic       last_byte;
    logic       len_bad;

    assign xfer      = lnk.in_valid & lnk.in_ready;
    assign data_xfer = (state_reg == ST_DATA) && xfer;
    assign last_byte = (add8(cnt_reg, 8'd1) == len_reg);
    assign len_bad   = (lnk.in_data == 8'h00) || (int'(lnk.in_data) > MAX_LEN);

`ifdef LOADER_CHECKSUM_EN
    logic csum_match;

    neander_loader_csum u_csum (
        .clk    (clk),
        .rst    (rst),
        .clear  (load_start),
        .add_en (data_xfer),
        .din    (lnk.in_data),
        .cmp    (lnk.in_data),
        .match  (csum_match)
    );
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode; start is honoured only outside a session.
    always_comb begin
        state_next = state_reg;
        load_start = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_next = ST_LEN;
                    load_start = 1'b1;
                end
            end
            ST_LEN: begin
                if (xfer) begin
                    state_next = len_bad ? ST_ERROR : ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer && last_byte) begin
`ifdef LOADER_CHECKSUM_EN
                    state_next = ST_CSUM;
`else
                    state_next = ST_DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (xfer) begin
                    state_next = csum_match ? ST_DONE : ST_ERROR;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // Length latch, payload counter and registered memory write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_reg       <= 8'h00;
            cnt_reg       <= 8'h00;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 8'h00;
            mem_wdata_reg <= 8'h00;
        end else begin
            mem_we_reg <= 1'b0;
            if (load_start) begin
                cnt_reg <= 8'h00;
            end
            if ((state_reg == ST_LEN) && xfer) begin
                len_reg <= lnk.in_data;
            end
            if (data_xfer) begin
                mem_we_reg    <= 1'b1;
                mem_addr_reg  <= add8(START_ADDR, cnt_reg);
                mem_wdata_reg <= lnk.in_data;
                cnt_reg       <= add8(cnt_reg, 8'd1);
            end
        end
    end

    assign lnk.in_ready  = (state_reg == ST_LEN) || (state_reg == ST_DATA) ||
                           (state_reg == ST_CSUM);
    assign lnk.mem_we    = mem_we_reg;
    assign lnk.mem_addr  = mem_addr_reg;
    assign lnk.mem_wdata = mem_wdata_reg;
    assign busy          = lnk.in_ready;
    assign done          = (state_reg == ST_DONE);
    assign err           = (state_reg == ST_ERROR);
    assign cpu_rst       = (state_reg != ST_DONE);
    assign byte_count    = cnt_reg;

endmodule

// File: tb/tb_neander_prog_loader.sv
// Directed bench for neander_prog_loader: streams length-prefixed loads
// and checks the memory writes, status outputs and CPU reset control.
module tb_neander_prog_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cpu_rst, busy, done, err;
    logic [7:0] byte_count;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;

    logic [7:0] wr_addr[$];
    logic [7:0] wr_data[$];
    int         wr_cyc[$];

    neander_prog_loader_if lnk ();

    neander_prog_loader #(.START_ADDR(8'h00), .MAX_LEN(128)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .lnk        (lnk),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Log every memory write strobe, one line per write.
    always @(negedge clk) begin
        if (lnk.mem_we === 1'b1) begin
            wr_addr.push_back(lnk.mem_addr);
            wr_data.push_back(lnk.mem_wdata);
            wr_cyc.push_back(cyc);
            $display("WR  addr=%02h data=%02h cycle=%0d", lnk.mem_addr, lnk.mem_wdata, cyc);
        end
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte after `gap` idle cycles; returns at the negedge after it transfers.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            lnk.in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (lnk.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL gap_in_ready: got %b want 1", lnk.in_ready);
            end
        end
        lnk.in_valid = 1'b1;
        lnk.in_data  = b;
        t = 0;
        while (lnk.in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %02h never accepted", b);
        end
        @(negedge clk);
        lnk.in_valid = 1'b0;
        $display("TX  byte=%02h", b);
    endtask

    // Trailing checksum byte, only in checksum builds.
    task automatic send_csum(input logic [7:0] b);
`ifdef LOADER_CHECKSUM_EN
        send_byte(b, 0);
`else
        if (b === 8'hxx) $display("no checksum byte");
`endif
    endtask

    task automatic test_reset();
        lnk.in_valid = 1'b0;
        lnk.in_data  = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cpu_rst, lnk.in_ready, lnk.mem_we, busy, done, err} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags: got cpu_rst/rdy/we/busy/done/err=%b want 100000",
                     {cpu_rst, lnk.in_ready, lnk.mem_we, busy, done, err});
        end
        checks++;
        if ({lnk.mem_addr, lnk.mem_wdata, byte_count} !== 24'h0) begin
            errors++;
            $display("FAIL reset_buses: got addr=%02h wdata=%02h count=%02h want 0",
                     lnk.mem_addr, lnk.mem_wdata, byte_count);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_rst !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got cpu_rst=%b busy=%b want 1 0", cpu_rst, busy);
        end
    endtask

    task automatic test_basic_load();
        logic [7:0] ea[3] = '{8'h00, 8'h01, 8'h02};
        logic [7:0] ed[3] = '{8'h11, 8'h22, 8'h33};
        clear_log();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || cpu_rst !== 1'b1 || lnk.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_len: got busy=%b cpu_rst=%b rdy=%b want 1 1 1", busy, cpu_rst, lnk.in_ready);
        end
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_csum(8'h66);
        repeat (2) @(negedge clk);
        checks++;
        if (wr_addr.size() !== 3) begin
            errors++;
            $display("FAIL basic_nwrites: got %0d want 3", wr_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_addr[i] !== ea[i] || wr_data[i] !== ed[i]) begin
                    errors++;
                    $display("FAIL basic_write%0d: got %02h@%02h want %02h@%02h",
                             i, wr_data[i], wr_addr[i], ed[i], ea[i]);
                end
            end
            checks++;
            if (wr_cyc[1] !== wr_cyc[0] + 1 || wr_cyc[2] !== wr_cyc[1] + 1) begin
                errors++;
                $display("FAIL basic_consecutive: got cycles %0d %0d %0d", wr_cyc[0], wr_cyc[1], wr_cyc[2]);
            end
        end
        checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || byte_count !== 8'd3) begin
            errors++;
            $display("FAIL basic_status: got done=%b cpu_rst=%b busy=%b err=%b count=%0d want 1 0 0 0 3",
                     done, cpu_rst, busy, err, byte_count);
        end
        checks++;
        if (lnk.mem_we !== 1'b0 || lnk.mem_addr !== 8'h02 || lnk.mem_wdata !== 8'h33) begin
            errors++;
            $display("FAIL basic_hold: got we=%b addr=%02h wdata=%02h want 0 02 33",
                     lnk.mem_we, lnk.mem_addr, lnk.mem_wdata);
        end
    endtask

    task automatic test_bad_length();
        logic [7:0] lens[2] = '{8'h00, 8'h81};
        for (int k = 0; k < 2; k++) begin
            clear_log();
            pulse_start();
            checks++;
            if (err !== 1'b0 || done !== 1'b0 || cpu_rst !== 1'b1) begin
                errors++;
                $display("FAIL badlen_start%0d: got err=%b done=%b cpu_rst=%b want 0 0 1", k, err, done, cpu_rst);
            end
            send_byte(lens[k], 0);
            repeat (2) @(negedge clk);
            checks++;
            if (err !== 1'b1 || cpu_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || wr_addr.size() !== 0) begin
                errors++;
                $display("FAIL badlen_%02h: got err=%b cpu_rst=%b busy=%b done=%b writes=%0d want 1 1 0 0 0",
                         lens[k], err, cpu_rst, busy, done, wr_addr.size());
            end
        end
    endtask

    task automatic test_gaps();
        clear_log();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'hAA, 2);
        send_byte(8'hBB, 2);
        send_csum(8'h65);
        repeat (2) @(negedge clk);
        checks++;
        if (wr_addr.size() !== 2) begin
            errors++;
            $display("FAIL gaps_nwrites: got %0d want 2", wr_addr.size());
        end else begin
            checks++;
            if (wr_addr[0] !== 8'h00 || wr_data[0] !== 8'hAA || wr_addr[1] !== 8'h01 || wr_data[1] !== 8'hBB) begin
                errors++;
                $display("FAIL gaps_writes: got %02h@%02h %02h@%02h want AA@00 BB@01",
                         wr_data[0], wr_addr[0], wr_data[1], wr_addr[1]);
            end
        end
        checks++;
        if (done !== 1'b1 || byte_count !== 8'd2) begin
            errors++;
            $display("FAIL gaps_status: got done=%b count=%0d want 1 2", done, byte_count);
        end
    endtask

    task automatic test_reset_mid_session();
        clear_log();
        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || cpu_rst !== 1'b1 || lnk.in_ready !== 1'b0 || byte_count !== 8'd0) begin
            errors++;
            $display("FAIL midrst: got busy=%b cpu_rst=%b rdy=%b count=%0d want 0 1 0 0",
                     busy, cpu_rst, lnk.in_ready, byte_count);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_log();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h5A, 0);
        send_csum(8'h5A);
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || wr_addr.size() !== 1 ||
            (wr_addr.size() == 1 && (wr_addr[0] !== 8'h00 || wr_data[0] !== 8'h5A))) begin
            errors++;
            $display("FAIL midrst_reload: got done=%b cpu_rst=%b writes=%0d want 1 0 1 (5A@00)",
                     done, cpu_rst, wr_addr.size());
        end
    endtask

    task automatic test_start_ignored();
        clear_log();
        pulse_start();
        send_byte(8'h03, 0);
        send_byte(8'hC1, 0);
        start = 1'b1;
        send_byte(8'hC2, 0);
        start = 1'b0;
        send_byte(8'hC3, 0);
        send_csum(8'h46);
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b1 || byte_count !== 8'd3 || wr_addr.size() !== 3 ||
            (wr_addr.size() == 3 && (wr_addr[2] !== 8'h02 || wr_data[2] !== 8'hC3))) begin
            errors++;
            $display("FAIL start_mid_data: got done=%b count=%0d writes=%0d want 1 3 3",
                     done, byte_count, wr_addr.size());
        end
        checks++;
        if (cpu_rst !== 1'b0) begin
            errors++;
            $display("FAIL done_release: got cpu_rst=%b want 0", cpu_rst);
        end
        clear_log();
        pulse_start();
        checks++;
        if (cpu_rst !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || byte_count !== 8'd0) begin
            errors++;
            $display("FAIL restart_from_done: got cpu_rst=%b busy=%b done=%b count=%0d want 1 1 0 0",
                     cpu_rst, busy, done, byte_count);
        end
        send_byte(8'h01, 0);
        send_byte(8'h7E, 0);
        send_csum(8'h7E);
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b1 || wr_addr.size() !== 1 || (wr_addr.size() == 1 && wr_data[0] !== 8'h7E)) begin
            errors++;
            $display("FAIL restart_load: got done=%b writes=%0d want 1 1 (7E@00)", done, wr_addr.size());
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        clear_log();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || wr_addr.size() !== 2) begin
            errors++;
            $display("FAIL csum_good: got done=%b err=%b writes=%0d want 1 0 2", done, err, wr_addr.size());
        end
        clear_log();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h04, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (err !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b1 || wr_addr.size() !== 2) begin
            errors++;
            $display("FAIL csum_bad: got err=%b done=%b cpu_rst=%b writes=%0d want 1 0 1 2",
                     err, done, cpu_rst, wr_addr.size());
        end
    endtask
`endif

    initial begin
        lnk.in_valid = 1'b0;
        lnk.in_data  = 8'h00;
        test_reset();
        test_basic_load();
        test_bad_length();
        test_gaps();
        test_reset_mid_session();
        test_start_ignored();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
